// File: rtl/mul_div_unit_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide unit.
package muldiv_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the control unit and the multiply/divide unit.
// op_unsigned is present only when MULDIV_UNSIGNED_EN is defined.
interface mul_div_unit_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             start;
  logic             op;
`ifdef MULDIV_UNSIGNED_EN
  logic             op_unsigned;
`endif
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] z_hi;
  logic [WIDTH-1:0] z_lo;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
`ifdef MULDIV_UNSIGNED_EN
    output op_unsigned,
`endif
    output start, op, operand_a, operand_b,
    input  z_hi, z_lo, busy, done, div_by_zero
  );

  modport slave (
`ifdef MULDIV_UNSIGNED_EN
    input  op_unsigned,
`endif
    input  start, op, operand_a, operand_b,
    output z_hi, z_lo, busy, done, div_by_zero
  );

endinterface

// File: rtl/mul_div_unit_step.sv
// One combinational iteration: radix-2 Booth add/sub + arithmetic shift, or
// restoring-division shift + trial subtract on magnitudes.
module mul_div_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             op,
  input  logic [WIDTH:0]   a_in,
  input  logic [WIDTH:0]   q_in,
  input  logic [WIDTH:0]   m_in,
  input  logic             qm1_in,
  output logic [WIDTH:0]   a_out,
  output logic [WIDTH:0]   q_out,
  output logic             qm1_out
);

  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH+1:0] trial;

  always_comb begin
    booth_sum = a_in;
    rem_shift = {a_in[WIDTH-1:0], q_in[WIDTH-1]};
    // Extra leading bit so the borrow is valid even when rem_shift exceeds 2^WIDTH
    trial     = {1'b0, rem_shift} - {1'b0, m_in};
    a_out     = a_in;
    q_out     = q_in;
    qm1_out   = qm1_in;

    if (op == OP_MUL) begin
      case ({q_in[0], qm1_in})
        2'b01:   booth_sum = a_in + m_in;
        2'b10:   booth_sum = a_in - m_in;
        default: booth_sum = a_in;
      endcase
      a_out   = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
      q_out   = {booth_sum[0], q_in[WIDTH:1]};
      qm1_out = q_in[0];
    end else if (trial[WIDTH+1]) begin
      a_out = rem_shift;
      q_out = {1'b0, q_in[WIDTH-2:0], 1'b0};
    end else begin
      a_out = trial[WIDTH:0];
      q_out = {1'b0, q_in[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle signed 32x32 multiply/divide producing the Z_HI/Z_LO pair.
// Defining MULDIV_UNSIGNED_EN adds op_unsigned for unsigned multiply/divide.
module mul_div_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic           clk,
  input  logic           clr_n,
  mul_div_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);
`ifdef MULDIV_UNSIGNED_EN
  localparam int CW = CNT_W + 1;
`else
  localparam int CW = CNT_W;
`endif

  state_t           state, state_nx;
  logic [CW-1:0]    count, count_init;
  logic             op_reg, uns_reg, zdiv_reg, neg_q, neg_r, dbz_reg;
  logic [WIDTH:0]   a_reg, q_reg, m_reg;
  logic             qm1_reg;
  logic [WIDTH-1:0] z_hi_reg, z_lo_reg, res_hi, res_lo;
  logic [WIDTH:0]   a_nx, q_nx;
  logic             qm1_nx;
  logic             uns_in, sgn, zdiv_in;
  logic [WIDTH-1:0] mag_a, mag_b;

`ifdef MULDIV_UNSIGNED_EN
  assign uns_in = bus.op_unsigned;
`else
  assign uns_in = 1'b0;
`endif

  assign sgn     = ~uns_in;
  assign zdiv_in = (bus.op == OP_DIV) && (bus.operand_b == '0);
  assign mag_a   = (sgn && bus.operand_a[WIDTH-1]) ? -bus.operand_a : bus.operand_a;
  assign mag_b   = (sgn && bus.operand_b[WIDTH-1]) ? -bus.operand_b : bus.operand_b;

  always_comb begin
    count_init = CW'(WIDTH - 1);
`ifdef MULDIV_UNSIGNED_EN
    // Zero-extended multiplier needs one more Booth step to cover its top bit
    if (uns_in && bus.op == OP_MUL) count_init = CW'(WIDTH);
`endif
  end

  mul_div_step #(.WIDTH(WIDTH)) u_step (
    .op      (op_reg),
    .a_in    (a_reg),
    .q_in    (q_reg),
    .m_in    (m_reg),
    .qm1_in  (qm1_reg),
    .a_out   (a_nx),
    .q_out   (q_nx),
    .qm1_out (qm1_nx)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.start) state_nx = zdiv_in ? FIX : RUN;
      RUN:  if (count == '0) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    res_hi = a_reg[WIDTH-1:0];
    res_lo = q_reg[WIDTH:1];
    if (zdiv_reg) begin
      res_hi = a_reg[WIDTH-1:0];
      res_lo = '1;
    end else if (op_reg == OP_MUL) begin
      if (uns_reg) begin
        res_hi = {a_reg[WIDTH-2:0], q_reg[WIDTH]};
        res_lo = q_reg[WIDTH-1:0];
      end
    end else begin
      res_lo = neg_q ? -q_reg[WIDTH-1:0] : q_reg[WIDTH-1:0];
      res_hi = neg_r ? -a_reg[WIDTH-1:0] : a_reg[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count    <= '0;
      op_reg   <= 1'b0;
      uns_reg  <= 1'b0;
      zdiv_reg <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dbz_reg  <= 1'b0;
      a_reg    <= '0;
      q_reg    <= '0;
      m_reg    <= '0;
      qm1_reg  <= 1'b0;
      z_hi_reg <= '0;
      z_lo_reg <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          op_reg   <= bus.op;
          uns_reg  <= uns_in;
          zdiv_reg <= zdiv_in;
          dbz_reg  <= 1'b0;
          count    <= count_init;
          qm1_reg  <= 1'b0;
          neg_q    <= sgn && (bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1]);
          neg_r    <= sgn && bus.operand_a[WIDTH-1];
          if (bus.op == OP_MUL) begin
            a_reg <= '0;
            m_reg <= {sgn & bus.operand_a[WIDTH-1], bus.operand_a};
            q_reg <= {sgn & bus.operand_b[WIDTH-1], bus.operand_b};
          end else begin
            // A zero divisor skips RUN; a_reg carries the dividend to z_hi
            a_reg <= zdiv_in ? {1'b0, bus.operand_a} : '0;
            m_reg <= {1'b0, mag_b};
            q_reg <= {1'b0, mag_a};
          end
        end
        RUN: begin
          a_reg   <= a_nx;
          q_reg   <= q_nx;
          qm1_reg <= qm1_nx;
          if (count != '0) count <= count - 1'b1;
        end
        FIX: begin
          z_hi_reg <= res_hi;
          z_lo_reg <= res_lo;
          dbz_reg  <= zdiv_reg;
        end
        default: ;
      endcase
    end
  end

  assign bus.z_hi        = z_hi_reg;
  assign bus.z_lo        = z_lo_reg;
  assign bus.busy        = (state == RUN) || (state == FIX);
  assign bus.done        = (state == DONE);
  assign bus.div_by_zero = dbz_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit against an arithmetic reference model.
// Unsigned cases are exercised when MULDIV_UNSIGNED_EN is defined.
module tb_mul_div_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic clr_n;
  int   checks = 0;
  int   failures = 0;
  logic [W-1:0] prev_hi, prev_lo;

  mul_div_unit_if #(.WIDTH(W)) bus ();

  mul_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] refResult(input logic op, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic uns);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == OP_MUL) begin
      if (uns) p = {32'b0, a} * {32'b0, b};
      else     p = sa * sb;
    end else if (b == '0) begin
      p = {a, 32'hFFFF_FFFF};
    end else if (uns) begin
      p = {a % b, a / b};
    end else begin
      q = sa / sb;
      r = sa % sb;
      p = {r[31:0], q[31:0]};
    end
    return p;
  endfunction

  function automatic int refLatency(input logic op, input logic [W-1:0] b, input logic uns);
    if (op == OP_DIV && b == '0) return 2;
    if (op == OP_MUL && uns)     return W + 3;
    return W + 2;
  endfunction

  // Runs one transaction from an IDLE cycle; optionally raises start in the DONE cycle
  task automatic applyStimulus(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic uns, input string name, input bit start_on_done);
    logic [63:0] exp;
    int lat, cyc;
    bit busy_ok, stable_ok;
    exp = refResult(op, a, b, uns);
    lat = refLatency(op, b, uns);
    bus.op = op;
    bus.operand_a = a;
    bus.operand_b = b;
`ifdef MULDIV_UNSIGNED_EN
    bus.op_unsigned = uns;
`endif
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.operand_a = $urandom;
    bus.operand_b = $urandom;
    bus.op = 1'($urandom_range(0, 1));
    checkOutput({name, " dbz_clear"}, 64'(bus.div_by_zero), 64'd0);
    cyc = 1;
    busy_ok = 1'b1;
    stable_ok = 1'b1;
    while (!bus.done && cyc < 100) begin
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.z_hi !== prev_hi || bus.z_lo !== prev_lo) stable_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput({name, " latency"}, 64'(cyc), 64'(lat));
    checkOutput({name, " busy_run"}, 64'(busy_ok), 64'd1);
    checkOutput({name, " z_stable"}, 64'(stable_ok), 64'd1);
    checkOutput({name, " z"}, {bus.z_hi, bus.z_lo}, exp);
    checkOutput({name, " dbz"}, 64'(bus.div_by_zero), 64'((op == OP_DIV) && (b == '0)));
    checkOutput({name, " busy_done"}, 64'(bus.busy), 64'd0);
    prev_hi = exp[63:32];
    prev_lo = exp[31:0];
    if (start_on_done) begin
      bus.start = 1'b1;
      bus.op = OP_MUL;
    end
    @(posedge clk); #1;
    checkOutput({name, " done_pulse"}, 64'(bus.done), 64'd0);
    checkOutput({name, " idle_after"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    bit abort_ok;
    logic          r_op, r_uns;
    logic [W-1:0]  r_a, r_b;

    bus.start = 1'b0;
    bus.op = OP_MUL;
    bus.operand_a = '0;
    bus.operand_b = '0;
`ifdef MULDIV_UNSIGNED_EN
    bus.op_unsigned = 1'b0;
`endif
    prev_hi = '0;
    prev_lo = '0;
    clr_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst z", {bus.z_hi, bus.z_lo}, 64'd0);
    checkOutput("rst busy", 64'(bus.busy), 64'd0);
    checkOutput("rst done", 64'(bus.done), 64'd0);
    checkOutput("rst dbz", 64'(bus.div_by_zero), 64'd0);
    clr_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed cases");
    applyStimulus(OP_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 1'b0, "mul_7_m3", 1'b0);
    applyStimulus(OP_MUL, 32'h8000_0000, 32'h8000_0000, 1'b0, "mul_min_min", 1'b0);
    applyStimulus(OP_DIV, 32'hFFFF_FFEF, 32'h0000_0005, 1'b0, "div_m17_5", 1'b0);
    applyStimulus(OP_DIV, 32'h0000_0064, 32'h0000_0000, 1'b0, "div_100_0", 1'b1);
    applyStimulus(OP_MUL, 32'h0000_3039, 32'hFFFF_FD5A, 1'b0, "mul_after_dbz", 1'b0);
    applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_min_m1", 1'b0);
    applyStimulus(OP_DIV, 32'h0000_0011, 32'hFFFF_FFFB, 1'b0, "div_17_m5", 1'b0);

    $display("[TB] abort by reset");
    bus.op = OP_MUL;
    bus.operand_a = 32'h0000_1234;
    bus.operand_b = 32'h0000_0055;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    abort_ok = 1'b1;
    for (int cyc = 1; cyc < 10; cyc++) begin
      if (!bus.busy || bus.done) abort_ok = 1'b0;
      if (cyc == 4) begin
        bus.start = 1'b1;
        bus.op = OP_DIV;
        bus.operand_b = '0;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
    end
    checkOutput("abort busy_run", 64'(abort_ok), 64'd1);
    clr_n = 1'b0;
    #1;
    checkOutput("abort z", {bus.z_hi, bus.z_lo}, 64'd0);
    checkOutput("abort busy", 64'(bus.busy), 64'd0);
    checkOutput("abort dbz", 64'(bus.div_by_zero), 64'd0);
    abort_ok = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) abort_ok = 1'b0;
    end
    clr_n = 1'b1;
    @(posedge clk); #1;
    if (bus.done || bus.busy) abort_ok = 1'b0;
    checkOutput("abort quiet", 64'(abort_ok), 64'd1);
    prev_hi = '0;
    prev_lo = '0;
    applyStimulus(OP_MUL, 32'h0000_1234, 32'h0000_0055, 1'b0, "after_abort", 1'b0);

`ifdef MULDIV_UNSIGNED_EN
    $display("[TB] unsigned cases");
    applyStimulus(OP_MUL, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, "umul", 1'b0);
    applyStimulus(OP_MUL, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, "smul", 1'b0);
    applyStimulus(OP_DIV, 32'hFFFF_FFEF, 32'h0000_0005, 1'b1, "udiv", 1'b0);
`endif

    $display("[TB] random cases");
    for (int i = 0; i < 40; i++) begin
      r_op = 1'($urandom_range(0, 1));
      r_a = $urandom;
      r_b = $urandom;
      case ($urandom_range(0, 7))
        0: r_b = '0;
        1: r_a = 32'h8000_0000;
        2: r_b = 32'hFFFF_FFFF;
        3: r_b = W'($urandom_range(1, 20));
        default: ;
      endcase
`ifdef MULDIV_UNSIGNED_EN
      r_uns = 1'($urandom_range(0, 1));
`else
      r_uns = 1'b0;
`endif
      applyStimulus(r_op, r_a, r_b, r_uns, "rand", 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    failures++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
